// File: rtl/bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_pkg : shared constants, state enum and segment decode helper     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bcd_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Active-low digit enables, an[0] = units, an[1] = tens
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;
  localparam logic [1:0] AN_OFF   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_sum_display_bcd_to_seg7.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_to_seg7 : combinational BCD digit to active-low 7-segment, E >9  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bcd_to_seg7
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = digit_to_seg(digit);
  end

endmodule
`default_nettype wire

// File: rtl/bcd_sum_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_sum_display : captures a 0..19 BCD sum and scans it onto a       |
// | 2-digit multiplexed 7-segment display. Revision: 1.0                 |
// +----------------------------------------------------------------------+
module bcd_sum_display
  import bcd_pkg::*;
#(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_carry,
  input  logic [3:0] in_digit,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       err,
  output logic       frame_done
);

  localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  state_e           state_q, state_d;
  logic             carry_q, carry_d;
  logic [3:0]       digit_q, digit_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             in_ready_q, in_ready_d;
  logic             frame_done_q, frame_done_d;

  logic             xfer;
  logic [3:0]       scan_digit;
  logic [6:0]       conv_seg;

  assign xfer = in_valid & in_ready_q;

  always_comb begin
    state_d      = state_q;
    carry_d      = carry_q;
    digit_d      = digit_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    in_ready_d   = in_ready_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d    = SHOW;
          carry_d    = in_carry;
          digit_d    = in_digit;
          err_d      = (in_digit > 4'd9);
          cnt_d      = '0;
          sel_d      = 1'b0;
          in_ready_d = 1'b0;
        end
      end
      SHOW: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sel_d = ~sel_q;
          // Leaving the tens slot completes a frame and reopens the input
          if (sel_q) begin
            frame_done_d = 1'b1;
            in_ready_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A new capture restarts the scan but never suppresses frame_done
        if (xfer) begin
          carry_d    = in_carry;
          digit_d    = in_digit;
          err_d      = (in_digit > 4'd9);
          cnt_d      = '0;
          sel_d      = 1'b0;
          in_ready_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      carry_q      <= 1'b0;
      digit_q      <= 4'd0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      carry_q      <= carry_d;
      digit_q      <= digit_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      in_ready_q   <= in_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Tens slot feeds the carry through the shared decoder so "1" comes for free
  assign scan_digit = sel_q ? {3'b000, carry_q} : digit_q;

  bcd_to_seg7 u_bcd_to_seg7 (
    .digit (scan_digit),
    .seg   (conv_seg)
  );

  always_comb begin
    an  = AN_OFF;
    seg = SEG_BLANK;
    if (state_q == SHOW) begin
      if (!sel_q) begin
        an  = AN_UNITS;
        seg = conv_seg;
      end else if (carry_q) begin
        an  = AN_TENS;
        seg = conv_seg;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign err        = err_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_sum_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bcd_sum_display : directed + random stimulus against a timing    |
// | model of the display. Revision: 1.0                                  |
// +----------------------------------------------------------------------+
module tb_bcd_sum_display;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_carry = 1'b0;
  logic [3:0] in_digit = 4'd0;
  logic [1:0] an;
  logic [6:0] seg;
  logic       err;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  // Model: whether a value is held, the value, and cycles since its capture
  bit   m_active = 0;
  bit   m_rdy    = 1;
  bit   m_fd     = 0;
  bit   m_carry  = 0;
  int   m_digit  = 0;
  int   m_age    = 0;
  logic [6:0] tbl [10];

  bcd_sum_display #(.REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_carry   (in_carry),
    .in_digit   (in_digit),
    .an         (an),
    .seg        (seg),
    .err        (err),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] e_an;
    logic [6:0] e_seg;
    bit         e_err;
    e_an  = 2'b11;
    e_seg = 7'h7F;
    e_err = 0;
    if (m_active) begin
      e_err = (m_digit > 9);
      if ((m_age % (2 * RD)) < RD) begin
        e_an  = 2'b10;
        e_seg = (m_digit > 9) ? 7'h06 : tbl[m_digit];
      end else if (m_carry) begin
        e_an  = 2'b01;
        e_seg = 7'h79;
      end
    end
    check("in_ready",   in_ready,   m_rdy);
    check("an",         an,         e_an);
    check("seg",        seg,        e_seg);
    check("err",        err,        e_err);
    check("frame_done", frame_done, m_fd);
  endtask

  task automatic tick();
    bit fe;
    bit xf;
    @(posedge clk);
    if (rst) begin
      m_active = 0; m_rdy = 1; m_fd = 0; m_age = 0; m_carry = 0; m_digit = 0;
    end else begin
      xf = in_valid && m_rdy;
      fe = 0;
      if (m_active) begin
        m_age++;
        fe = ((m_age % (2 * RD)) == 0);
        if (fe) m_rdy = 1;
      end
      m_fd = fe;
      if (xf) begin
        m_active = 1; m_carry = in_carry; m_digit = int'(in_digit);
        m_age = 0; m_rdy = 0;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !m_rdy; i++) tick();
  endtask

  task automatic send(input bit c, input logic [3:0] d);
    wait_ready();
    in_valid = 1'b1;
    in_carry = c;
    in_digit = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = 7'h40; tbl[1] = 7'h79; tbl[2] = 7'h24; tbl[3] = 7'h30; tbl[4] = 7'h19;
    tbl[5] = 7'h12; tbl[6] = 7'h02; tbl[7] = 7'h78; tbl[8] = 7'h00; tbl[9] = 7'h10;

    // Reset then idle
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset_seg", seg, 7'h7F);
    for (int i = 0; i < 10; i++) tick();

    // carry=1 digit=4: a full frame and then some
    send(1'b1, 4'd4);
    check("units_4", seg, 7'h19);
    for (int i = 0; i < 10; i++) tick();

    // carry=0 digit=7: tens blanked
    send(1'b0, 4'd7);
    check("units_7", seg, 7'h78);
    for (int i = 0; i < 9; i++) tick();

    // Non-BCD digit raises err, valid digit clears it
    send(1'b0, 4'hB);
    check("err_set", err, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    send(1'b1, 4'd3);
    check("err_clr", err, 1'b0);
    for (int i = 0; i < 9; i++) tick();

    // Continuous valid with alternating values
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_carry = i[0];
      in_digit = i[0] ? 4'd2 : 4'd9;
      tick();
    end
    in_valid = 1'b0;

    // Reset mid-frame
    send(1'b1, 4'd5);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_an", an, 2'b11);
    for (int i = 0; i < 10; i++) tick();

    // Randomised traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_carry = 1'($urandom_range(0, 1));
      in_digit = 4'($urandom_range(0, 15));
      rst      = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
